wb_interlock: RTL and testbench

- Producer side of the operand-bypass bus. Owns the WB stage and drives the write-back triple `wb_reg_wr_en` / `wb_dest_addr` / `wb_wr_data`. The forwarding unit and register file consume that triple.
- Tracks outstanding data-memory loads in an in-order load queue.
- Arbitrates ALU results against load responses using a 1-entry skid register.
- Raises load-use and WAW interlocks, since forwarding only covers data already on the WB port.
- Sits between EX/MEM and the register file.

---
 rtl/wb_interlock_pkg.sv | 21 ++
 rtl/wb_interlock_if.sv | 49 ++++
 rtl/wb_load_queue.sv | 59 +++++
 rtl/wb_interlock.sv | 132 +++++++++++++
 tb/tb_wb_interlock.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_interlock_pkg.sv
// Shared constants and types for the write-back interlock block.
package wb_interlock_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int OP3_ADDR_W = 3;

  // Which event the WB stage latches on the next edge.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LOAD = 2'd1,
    WB_SKID = 2'd2,
    WB_ALU  = 2'd3
  } wb_src_e;

  // One-hot register bit for a register address.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_interlock_if.sv
// Bypass-bus bundle: EX/MEM/ID inputs and WB/interlock outputs.
interface wb_interlock_if
  import wb_interlock_pkg::*;
#(
  parameter int NUM_DOMAINS = 1
);
  localparam int DW = NUM_DOMAINS * 8;

  logic                  ex_valid;
  logic                  ex_wr_en;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_dest_addr;
  logic [DW-1:0]         ex_alu_result;
  logic                  mem_rsp_valid;
  logic [DW-1:0]         mem_rsp_data;
  logic [REG_ADDR_W-1:0] id_op1_addr;
  logic [REG_ADDR_W-1:0] id_op2_addr;
  logic [OP3_ADDR_W-1:0] id_op3_addr;
  logic [2:0]            id_op_used;

  logic                  stall_ex;
  logic                  stall_ifid;
  logic                  bubble_idex;
  logic                  wb_reg_wr_en;
  logic [REG_ADDR_W-1:0] wb_dest_addr;
  logic [DW-1:0]         wb_wr_data;
  logic                  wb_load_true;
  logic [NUM_REGS-1:0]   pending_mask;
  logic                  load_err;

  // Pipeline side driving the block.
  modport master (
    output ex_valid, ex_wr_en, ex_is_load, ex_dest_addr, ex_alu_result,
           mem_rsp_valid, mem_rsp_data, id_op1_addr, id_op2_addr,
           id_op3_addr, id_op_used,
    input  stall_ex, stall_ifid, bubble_idex, wb_reg_wr_en, wb_dest_addr,
           wb_wr_data, wb_load_true, pending_mask, load_err
  );

  // The interlock block itself.
  modport slave (
    input  ex_valid, ex_wr_en, ex_is_load, ex_dest_addr, ex_alu_result,
           mem_rsp_valid, mem_rsp_data, id_op1_addr, id_op2_addr,
           id_op3_addr, id_op_used,
    output stall_ex, stall_ifid, bubble_idex, wb_reg_wr_en, wb_dest_addr,
           wb_wr_data, wb_load_true, pending_mask, load_err
  );

endinterface

// File: rtl/wb_load_queue.sv
// In-order queue of outstanding load destinations. Pointers carry one
// extra wrap bit so full/empty is decided by comparing MSBs.
module wb_load_queue
  import wb_interlock_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [REG_ADDR_W-1:0]            push_addr,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic [REG_ADDR_W-1:0]            head,
  output logic [DEPTH-1:0]                 ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr, cnt;
  logic do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push && (!full || do_pop);
  assign cnt     = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign ent_addr = mem;

  // Entry g is live when its distance from the head is below the fill count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    localparam logic [AW-1:0] IDX = AW'(g);
    logic [AW-1:0] off;
    assign off        = IDX - rd_ptr[AW-1:0];
    assign ent_vld[g] = ({1'b0, off} < cnt);
  end

  // Pointer update; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Destination storage; contents are qualified by ent_vld so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_addr;
  end

endmodule

// File: rtl/wb_interlock.sv
// WB-stage owner: arbitrates load responses against ALU results through a
// one-entry skid, tracks outstanding loads and raises load-use/WAW stalls.
module wb_interlock
  import wb_interlock_pkg::*;
#(
  parameter int NUM_DOMAINS = 1,
  parameter int LQ_DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  wb_interlock_if.slave bus
);
  localparam int DW = NUM_DOMAINS * 8;

  logic                                q_full, q_empty, q_push, rsp_pop;
  logic [REG_ADDR_W-1:0]               q_head;
  logic [LQ_DEPTH-1:0]                 ent_vld;
  logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;

  logic                  skid_vld;
  logic [REG_ADDR_W-1:0] skid_dest;
  logic [DW-1:0]         skid_data;

  logic                  wb_en_q, wb_load_q, load_err_q;
  logic [REG_ADDR_W-1:0] wb_dest_q;
  logic [DW-1:0]         wb_data_q;

  logic [NUM_REGS-1:0] pend_mask, busy_mask;
  logic                stall_ex, consume, alu_cand, waw, id_hit;
  wb_src_e             wb_sel;

  wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_addr (bus.ex_dest_addr),
    .pop       (rsp_pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  // Registers with a load in flight.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_addr[i]);
  end

  assign rsp_pop  = bus.mem_rsp_valid && !q_empty;
  assign waw      = (bus.ex_is_load || bus.ex_wr_en) && pend_mask[bus.ex_dest_addr];
  assign stall_ex = bus.ex_valid && (
                      (bus.ex_is_load && q_full && !rsp_pop) ||
                      waw ||
                      (!bus.ex_is_load && bus.ex_wr_en && skid_vld));
  assign consume  = bus.ex_valid && !stall_ex;
  assign q_push   = consume && bus.ex_is_load;
  assign alu_cand = consume && !bus.ex_is_load && bus.ex_wr_en;

  // Registers whose value is not yet visible on the WB port.
  always_comb begin
    busy_mask = pend_mask;
    if (skid_vld) busy_mask = busy_mask | reg_onehot(skid_dest);
    if (q_push)   busy_mask = busy_mask | reg_onehot(bus.ex_dest_addr);
  end

  assign id_hit = (bus.id_op_used[0] && busy_mask[bus.id_op1_addr]) ||
                  (bus.id_op_used[1] && busy_mask[bus.id_op2_addr]) ||
                  (bus.id_op_used[2] && busy_mask[{1'b0, bus.id_op3_addr}]);

  // WB source priority: load response, then skid, then fresh ALU result.
  always_comb begin
    wb_sel = WB_NONE;
    if (rsp_pop)       wb_sel = WB_LOAD;
    else if (skid_vld) wb_sel = WB_SKID;
    else if (alu_cand) wb_sel = WB_ALU;
  end

  // WB register, skid and sticky error update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_q    <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      skid_vld   <= 1'b0;
      skid_dest  <= '0;
      skid_data  <= '0;
      load_err_q <= 1'b0;
    end else begin
      if (bus.mem_rsp_valid && q_empty) load_err_q <= 1'b1;
      wb_en_q   <= (wb_sel != WB_NONE);
      wb_load_q <= (wb_sel == WB_LOAD);
      case (wb_sel)
        WB_LOAD: begin
          wb_dest_q <= q_head;
          wb_data_q <= bus.mem_rsp_data;
        end
        WB_SKID: begin
          wb_dest_q <= skid_dest;
          wb_data_q <= skid_data;
        end
        WB_ALU: begin
          wb_dest_q <= bus.ex_dest_addr;
          wb_data_q <= bus.ex_alu_result;
        end
        default: ;
      endcase
      // A skid-occupied cycle blocks new ALU writes, so it cannot overflow.
      if (wb_sel == WB_SKID) begin
        skid_vld <= 1'b0;
      end else if (wb_sel == WB_LOAD && alu_cand) begin
        skid_vld  <= 1'b1;
        skid_dest <= bus.ex_dest_addr;
        skid_data <= bus.ex_alu_result;
      end
    end
  end

  assign bus.stall_ex     = stall_ex;
  assign bus.stall_ifid   = stall_ex || id_hit;
  assign bus.bubble_idex  = id_hit && !stall_ex;
  assign bus.wb_reg_wr_en = wb_en_q;
  assign bus.wb_dest_addr = wb_dest_q;
  assign bus.wb_wr_data   = wb_data_q;
  assign bus.wb_load_true = wb_load_q;
  assign bus.pending_mask = pend_mask;
  assign bus.load_err     = load_err_q;

endmodule

// File: tb/tb_wb_interlock.sv
// Directed bench: expected WB writes go into a scoreboard queue, a negedge
// monitor pops and compares them; interlock outputs are checked inline.
module tb_wb_interlock;
  import wb_interlock_pkg::*;

  typedef struct {
    logic [3:0] dest;
    logic [7:0] data;
    logic       ld;
    int         cyc;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  wb_exp_t sb[$];

  wb_interlock_if #(.NUM_DOMAINS(1)) bus ();

  wb_interlock #(.NUM_DOMAINS(1), .LQ_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every WB write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.wb_reg_wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected dest=%0h data=%0h cyc=%0d", bus.wb_dest_addr, bus.wb_wr_data, cyc);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        if (bus.wb_dest_addr !== e.dest || bus.wb_wr_data !== e.data ||
            bus.wb_load_true !== e.ld || cyc != e.cyc) begin
          failures++;
          $display("FAIL wb_write act=r%0h/%0h/ld%0b@%0d exp=r%0h/%0h/ld%0b@%0d",
                   bus.wb_dest_addr, bus.wb_wr_data, bus.wb_load_true, cyc,
                   e.dest, e.data, e.ld, e.cyc);
        end
      end
    end
  end

  task automatic expect_wb(input logic [3:0] d, input logic [7:0] v, input logic ld, input int lat);
    wb_exp_t e;
    e.dest = d; e.data = v; e.ld = ld; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ex_valid = 0; bus.ex_wr_en = 0; bus.ex_is_load = 0;
    bus.ex_dest_addr = 0; bus.ex_alu_result = 0;
    bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0;
    bus.id_op1_addr = 0; bus.id_op2_addr = 0; bus.id_op3_addr = 0; bus.id_op_used = 0;
  endtask

  task automatic alu(input logic [3:0] d, input logic [7:0] v);
    bus.ex_valid = 1; bus.ex_wr_en = 1; bus.ex_is_load = 0;
    bus.ex_dest_addr = d; bus.ex_alu_result = v;
  endtask

  task automatic ld(input logic [3:0] d);
    bus.ex_valid = 1; bus.ex_wr_en = 1; bus.ex_is_load = 1; bus.ex_dest_addr = d;
  endtask

  task automatic rsp(input logic [7:0] v);
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = v;
  endtask

  task automatic ex_off();
    bus.ex_valid = 0; bus.ex_wr_en = 0; bus.ex_is_load = 0;
  endtask

  initial begin
    idle();
    // Reset held with a write presented.
    rst_n = 0;
    alu(4'd3, 8'hFF);
    tick(); tick(); half();
    chk("rst_wb_en", bus.wb_reg_wr_en, 0);
    chk("rst_wb_dest", bus.wb_dest_addr, 0);
    chk("rst_wb_data", bus.wb_wr_data, 0);
    chk("rst_wb_ld", bus.wb_load_true, 0);
    chk("rst_pending", bus.pending_mask, 0);
    chk("rst_load_err", bus.load_err, 0);
    tick(); rst_n = 1; idle(); tick();

    // ALU latency: r3=0x5A shows up one cycle later.
    alu(4'd3, 8'h5A); half();
    chk("alu_stall_ex", bus.stall_ex, 0);
    expect_wb(4'd3, 8'h5A, 0, 1);
    tick(); idle(); tick(); half();
    chk("hold_wb_en", bus.wb_reg_wr_en, 0);
    chk("hold_wb_dest", bus.wb_dest_addr, 3);
    chk("hold_wb_data", bus.wb_wr_data, 8'h5A);

    // Load-use: load r5, ID uses op2=r5.
    tick();
    ld(4'd5); bus.id_op2_addr = 4'd5; bus.id_op_used = 3'b010; half();
    chk("lu_same_cyc_stall_ifid", bus.stall_ifid, 1);
    chk("lu_same_cyc_bubble", bus.bubble_idex, 1);
    tick(); ex_off(); half();
    chk("lu_pending", bus.pending_mask, 16'h0020);
    chk("lu_stall_ifid", bus.stall_ifid, 1);
    chk("lu_bubble", bus.bubble_idex, 1);
    tick(); rsp(8'h11); expect_wb(4'd5, 8'h11, 1, 1);
    tick(); bus.mem_rsp_valid = 0; half();
    chk("lu_release_stall", bus.stall_ifid, 0);
    chk("lu_release_bubble", bus.bubble_idex, 0);
    chk("lu_release_mask", bus.pending_mask, 0);
    tick(); idle();

    // Collision: ALU r2 and response for r7 in the same cycle.
    ld(4'd7); tick();
    alu(4'd2, 8'h22); rsp(8'h33); half();
    chk("col_stall_ex", bus.stall_ex, 0);
    expect_wb(4'd7, 8'h33, 1, 1);
    expect_wb(4'd2, 8'h22, 0, 2);
    tick(); bus.mem_rsp_valid = 0; alu(4'd9, 8'h99); half();
    chk("skid_stall_ex", bus.stall_ex, 1);
    chk("skid_stall_ifid", bus.stall_ifid, 1);
    chk("skid_bubble", bus.bubble_idex, 0);
    tick(); half();
    chk("skid_free_stall_ex", bus.stall_ex, 0);
    expect_wb(4'd9, 8'h99, 0, 1);
    tick(); idle(); tick();

    // Queue full with two loads outstanding.
    ld(4'd1); tick(); ld(4'd4); tick();
    ld(4'd6); half();
    chk("full_stall_ex", bus.stall_ex, 1);
    chk("full_stall_ifid", bus.stall_ifid, 1);
    chk("full_bubble", bus.bubble_idex, 0);
    chk("full_mask", bus.pending_mask, 16'h0012);
    tick(); rsp(8'hA1); half();
    chk("full_pop_push_stall", bus.stall_ex, 0);
    expect_wb(4'd1, 8'hA1, 1, 1);
    tick(); idle(); bus.id_op3_addr = 3'd4; bus.id_op_used = 3'b100; half();
    chk("full_mask_after", bus.pending_mask, 16'h0050);
    chk("op3_stall_ifid", bus.stall_ifid, 1);
    chk("op3_bubble", bus.bubble_idex, 1);
    rsp(8'hB4); expect_wb(4'd4, 8'hB4, 1, 1);
    tick(); rsp(8'hC6); expect_wb(4'd6, 8'hC6, 1, 1);
    tick(); idle(); tick();

    // WAW: ALU r1 while a load to r1 is pending.
    ld(4'd1); tick();
    alu(4'd1, 8'h77); half();
    chk("waw_stall", bus.stall_ex, 1);
    tick(); rsp(8'hD1); half();
    chk("waw_stall_rsp_cyc", bus.stall_ex, 1);
    expect_wb(4'd1, 8'hD1, 1, 1);
    tick(); bus.mem_rsp_valid = 0; half();
    chk("waw_release", bus.stall_ex, 0);
    expect_wb(4'd1, 8'h77, 0, 1);
    tick(); idle(); tick();

    // Response with nothing queued.
    rsp(8'hEE); tick(); idle(); half();
    chk("err_set", bus.load_err, 1);
    chk("err_no_wb", bus.wb_reg_wr_en, 0);
    tick(); tick(); half();
    chk("err_sticky", bus.load_err, 1);

    // Reset mid-operation drops queued loads and the error.
    tick(); ld(4'd8); tick(); idle(); half();
    chk("pre_rst_mask", bus.pending_mask, 16'h0100);
    tick(); rst_n = 0; tick(); rst_n = 1; half();
    chk("mid_rst_mask", bus.pending_mask, 0);
    chk("mid_rst_err", bus.load_err, 0);
    tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
